fetch_seq_ctrl: RTL and testbench

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

---
 rtl/fetch_seq_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: PC register plus a FETCH/HOLD/DRAIN control FSM.
// Optional EXC_REDIRECT_EN adds the ExcReq port and a top-priority jump to EXC_PC.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter logic [31:0] EXC_PC   = 32'h00004180
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic        JmpEn,
  input  logic [31:0] JmpTarget,
`ifdef EXC_REDIRECT_EN
  input  logic        ExcReq,
`endif
  input  logic        IAck,
  output logic        IReq,
  output logic [31:0] IAddr,
  output logic        IValid,
  output logic [31:0] PC,
  output logic [1:0]  StateDbg
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redir;
  logic [31:0] redir_tgt_raw;
  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;

`ifdef EXC_REDIRECT_EN
  assign redir         = ExcReq | JmpEn | BrTaken;
  assign redir_tgt_raw = ExcReq ? EXC_PC : (JmpEn ? JmpTarget : BrTarget);
`else
  logic unused_exc_pc;
  assign unused_exc_pc = ^EXC_PC;
  assign redir         = JmpEn | BrTaken;
  assign redir_tgt_raw = JmpEn ? JmpTarget : BrTarget;
`endif

  // Targets are word aligned before reaching PC or the pending register.
  assign redir_tgt = {redir_tgt_raw[31:2], 2'b00};
  assign pc_inc    = pc_q + 32'd4;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_FETCH: begin
        if (IAck) begin
          if (redir) begin
            pc_d = redir_tgt;
          end else if (!Stall) begin
            pc_d = pc_inc;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (redir) begin
          pend_d  = redir_tgt;
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = ST_FETCH;
        end else if (!Stall) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The outstanding word is thrown away; the newest redirect wins.
        if (IAck) begin
          pc_d    = redir ? redir_tgt : pend_q;
          state_d = ST_FETCH;
        end else if (redir) begin
          pend_d = redir_tgt;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    IReq     = !Rst && (state_q != ST_HOLD);
    IValid   = !Rst && (state_q == ST_FETCH) && IAck && !redir;
    IAddr    = pc_q;
    PC       = pc_q;
    StateDbg = state_q;
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: a vector table plus hand-written corner sequences.
// Build with EXC_REDIRECT_EN defined to also cover the exception redirect.
module tb_fetch_seq_ctrl;

  localparam logic [1:0] S_F = 2'd0;
  localparam logic [1:0] S_H = 2'd1;
  localparam logic [1:0] S_D = 2'd2;

  logic        clk = 1'b0;
  logic        rst, stall, br, jmp, exc, iack;
  logic [31:0] br_tgt, jmp_tgt;
  logic        ireq, ivalid;
  logic [31:0] iaddr, pc;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_seq_ctrl dut (
    .Clk(clk), .Rst(rst), .Stall(stall),
    .BrTaken(br), .BrTarget(br_tgt), .JmpEn(jmp), .JmpTarget(jmp_tgt),
`ifdef EXC_REDIRECT_EN
    .ExcReq(exc),
`endif
    .IAck(iack), .IReq(ireq), .IAddr(iaddr), .IValid(ivalid), .PC(pc),
    .StateDbg(state_dbg)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
    logic        ack;
    logic        e_ireq, e_ivalid;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic e, input logic a);
    rst = r; stall = s; br = b; br_tgt = bt; jmp = j; jmp_tgt = jt; exc = e; iack = a;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic a,
                              input logic eq, input logic ev, input logic [31:0] ep,
                              input logic [1:0] es);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.brt = bt; v.jmp = j; v.jmpt = jt; v.ack = a;
    v.e_ireq = eq; v.e_ivalid = ev; v.e_pc = ep; v.e_st = es;
    return v;
  endfunction

  initial begin
    logic [31:0] model_pc;
    int          pulses;
    int          hold_cycles;
    idle();
    model_pc = 32'h0;

    //           rst st br brt           j  jt            ack  ireq iv  pc_after      st
    vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   0,   0,  32'h00003000, S_F);
    vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   0,   0,  32'h00003000, S_F);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003004, S_F);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003008, S_F);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h0000300C, S_F);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0,   1,   0,  32'h0000300C, S_F);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003010, S_F);
    vecs[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003010, S_H);
    vecs[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1,   0,   0,  32'h00003010, S_H);
    vecs[9]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0,   0,   0,  32'h00003010, S_H);
    vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0,   0,   0,  32'h00003014, S_F);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003018, S_F);
    vecs[12] = mk(0, 0, 1, 32'h00003103, 0, 32'h0,        0,   1,   0,  32'h00003018, S_D);
    vecs[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0,   1,   0,  32'h00003018, S_D);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   0,  32'h00003100, S_F);
    vecs[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003104, S_F);
    vecs[16] = mk(0, 0, 1, 32'h00005000, 1, 32'h00004000, 1,   1,   0,  32'h00004000, S_F);
    vecs[17] = mk(0, 0, 1, 32'h00005000, 0, 32'h0,        0,   1,   0,  32'h00004000, S_D);
    vecs[18] = mk(0, 0, 0, 32'h0,        1, 32'h00006001, 0,   1,   0,  32'h00004000, S_D);
    vecs[19] = mk(0, 0, 1, 32'h00007002, 0, 32'h0,        1,   1,   0,  32'h00007000, S_F);
    vecs[20] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00007000, S_H);
    vecs[21] = mk(0, 1, 1, 32'h00008004, 0, 32'h0,        0,   0,   0,  32'h00008004, S_F);
    vecs[22] = mk(0, 0, 0, 32'h0,        1, 32'hFFFFFFFF, 0,   1,   0,  32'h00008004, S_D);
    vecs[23] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   0,  32'hFFFFFFFC, S_F);
    vecs[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00000000, S_F);
    vecs[25] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00000000, S_H);
    vecs[26] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0,   0,   0,  32'h00003000, S_F);
    vecs[27] = mk(0, 0, 1, 32'h00009000, 0, 32'h0,        0,   1,   0,  32'h00003000, S_D);
    vecs[28] = mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   0,   0,  32'h00003000, S_F);
    vecs[29] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0,   1,   0,  32'h00003000, S_F);
    vecs[30] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1,   1,   1,  32'h00003004, S_F);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].brt,
            vecs[i].jmp, vecs[i].jmpt, 1'b0, vecs[i].ack);
      #1;
      check($sformatf("v%0d ireq", i), {31'b0, ireq}, {31'b0, vecs[i].e_ireq});
      check($sformatf("v%0d ivalid", i), {31'b0, ivalid}, {31'b0, vecs[i].e_ivalid});
      if (i > 0) check($sformatf("v%0d iaddr", i), iaddr, model_pc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d state", i), {30'b0, state_dbg}, {30'b0, vecs[i].e_st});
      model_pc = vecs[i].e_pc;
    end

    // Ack held high across a long stall: exactly one IValid pulse for PC 0x3004.
    pulses = 0;
    hold_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      if (ivalid) pulses++;
      if (!ireq) hold_cycles++;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("stall ivalid pulses", pulses, 1);
    check("stall hold cycles", hold_cycles, 4);
    check("stall release pc", pc, 32'h00003008);
    check("stall release ireq", {31'b0, ireq}, 32'd1);

`ifdef EXC_REDIRECT_EN
    // Enter HOLD, then exception and jump together: exception vector wins.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("exc pre hold state", {30'b0, state_dbg}, {30'b0, S_H});
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00004000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("exc hold pc", pc, 32'h00004180);
    check("exc hold state", {30'b0, state_dbg}, {30'b0, S_F});
    // Exception from FETCH with ack beats a branch too.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h00005000, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    check("exc fetch ivalid", {31'b0, ivalid}, 32'd0);
    @(posedge clk);
    #1;
    check("exc fetch pc", pc, 32'h00004180);
    // Reset while draining.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00006000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("exc drain state", {30'b0, state_dbg}, {30'b0, S_D});
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("exc rst pc", pc, 32'h00003000);
    check("exc rst state", {30'b0, state_dbg}, {30'b0, S_F});
`endif

    @(negedge clk);
    idle();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
